// File: rtl/rx_signal_parser.sv
// rx_signal_parser: strips RX framing from a descrambled bitstream.
// Parses the SIGNAL field, skips SERVICE, repacks the PSDU MSB-first.
//
// Ports:
//   iClk, iRst(async, active-low)
//   iStart  : frame start pulse (honoured in IDLE only)
//   iData   : serial bit, qualified by iValid
//   oRate   : {R1..R4}, first bit in MSB
//   oLength : PSDU length in bytes, LSB first on the wire
//   oSigValid / oSigErr : SIGNAL verdict pulses
//   oByte / oByteValid  : repacked PSDU byte and its strobe
//   oDone   : pulse after the last byte
//   oBusy   : high in SIG, SVC and DATA
module rx_signal_parser #(
   parameter int SERVICE_BITS = 16,
   parameter int LEN_W        = 12
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   input  logic             iData,
   input  logic             iValid,
   output logic [3:0]       oRate,
   output logic [LEN_W-1:0] oLength,
   output logic             oSigValid,
   output logic             oSigErr,
   output logic [7:0]       oByte,
   output logic             oByteValid,
   output logic             oDone,
   output logic             oBusy
);

   // SIGNAL: 4 rate, 1 reserved, LEN_W length, 1 parity, 6 tail
   localparam int SIG_BITS = LEN_W + 12;
   localparam int PAR_IX   = 5 + LEN_W;
   localparam int MAXC     =
      (SERVICE_BITS > SIG_BITS) ? SERVICE_BITS : SIG_BITS;
   localparam int CW       = $clog2(MAXC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SIG,
      S_SVC,
      S_DATA,
      S_DONE,
      S_ERR
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]       r_bitCnt;
   logic [SIG_BITS-2:0] r_sig;
   logic [6:0]          r_shift;
   logic [LEN_W-1:0]    r_byteCnt;

   logic [SIG_BITS-1:0] w_sig;
   logic [LEN_W-1:0]    w_len;
   logic                w_sigLast;
   logic                w_sigOk;
   logic                w_svcLast;
   logic                w_dataEnd;
   logic                w_byteLast;

   // full SIGNAL word as seen on the edge sampling its last bit
   assign w_sig = {iData, r_sig};
   assign w_len = w_sig[5 +: LEN_W];

   assign w_sigLast = (r_state == S_SIG) && iValid &&
                      (r_bitCnt == CW'(SIG_BITS - 1));
   assign w_sigOk   = w_sig[3] &&
                      !(^w_sig[PAR_IX:0]) &&
                      (w_sig[SIG_BITS-1:PAR_IX+1] == 6'd0) &&
                      (w_len != '0);
   assign w_svcLast = (r_state == S_SVC) && iValid &&
                      (r_bitCnt == CW'(SERVICE_BITS - 1));
   // all bytes out: bits past this point are dropped
   assign w_dataEnd = (r_state == S_DATA) &&
                      (r_byteCnt == oLength);
   assign w_byteLast = (r_state == S_DATA) && iValid &&
                       !w_dataEnd && (r_bitCnt[2:0] == 3'd7);

   assign oSigErr = (r_state == S_ERR);
   assign oDone   = (r_state == S_DONE);
   assign oBusy   = (r_state == S_SIG) ||
                    (r_state == S_SVC) ||
                    (r_state == S_DATA);

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (iStart) w_next = S_SIG;
         S_SIG:  if (w_sigLast)
                    w_next = w_sigOk ? S_SVC : S_ERR;
         S_SVC:  if (w_svcLast) w_next = S_DATA;
         S_DATA: if (w_dataEnd) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         S_ERR:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         r_bitCnt   <= '0;
         r_sig      <= '0;
         r_shift    <= '0;
         r_byteCnt  <= '0;
         oRate      <= '0;
         oLength    <= '0;
         oSigValid  <= 1'b0;
         oByte      <= '0;
         oByteValid <= 1'b0;
      end else begin
         oSigValid  <= 1'b0;
         oByteValid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (iStart) begin
                  r_bitCnt  <= '0;
                  r_sig     <= '0;
                  r_byteCnt <= '0;
                  oRate     <= '0;
                  oLength   <= '0;
               end
            end
            S_SIG: begin
               if (w_sigLast) begin
                  r_bitCnt  <= '0;
                  oRate     <= {w_sig[0], w_sig[1],
                                w_sig[2], w_sig[3]};
                  oLength   <= w_len;
                  oSigValid <= w_sigOk;
               end else if (iValid) begin
                  r_sig[r_bitCnt] <= iData;
                  r_bitCnt        <= r_bitCnt + 1'b1;
               end
            end
            S_SVC: begin
               if (w_svcLast)   r_bitCnt <= '0;
               else if (iValid) r_bitCnt <= r_bitCnt + 1'b1;
            end
            S_DATA: begin
               if (w_byteLast) begin
                  oByte      <= {r_shift, iData};
                  oByteValid <= 1'b1;
                  r_byteCnt  <= r_byteCnt + 1'b1;
                  r_bitCnt   <= '0;
               end else if (iValid && !w_dataEnd) begin
                  r_shift  <= {r_shift[5:0], iData};
                  r_bitCnt <= r_bitCnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
